xif_copro_issue_ctrl: RTL and testbench
=======================================

XIF_COPRO_ISSUE_CTRL -- requirements
Module: xif_copro_issue_ctrl
(Coprocessor-side end of the CORE-V-XIF issue/commit/result channels; executes a small custom-0 ALU subset.)

Interface
REQ-001 SHALL have parameters: ID_WIDTH, default 4, offload id width; DEPTH, default 4, outstanding-entry queue depth (power of 2, >=2).
REQ-002 SHALL have ports, in this order:
 clk_i  in  1  single clock; all logic on its rising edge
 rst_i  in  1  synchronous, active-high reset
 issue_valid_i  in  1  issue request valid
 issue_ready_o  out  1  issue request ready
 issue_instr_i  in  32  offloaded instruction
 issue_id_i  in  ID_WIDTH  offload id
 issue_rs0_i / issue_rs1_i  in  32 each  source operands
 issue_rs_valid_i  in  2  operand validity {rs1,rs0}
 issue_accept_o  out  1  instruction accepted
 issue_writeback_o  out  1  will write rd
 commit_valid_i  in  1  commit valid
 commit_id_i  in  ID_WIDTH  commit id
 commit_kill_i  in  1  kill (1) or commit (0)
 result_valid_o  out  1  result valid
 result_ready_i  in  1  result ready
 result_id_o  out  ID_WIDTH  result id
 result_data_o  out  32  rd write data
 result_rd_o  out  5  destination register
 result_we_o  out  1  register write enable
REQ-003 Reset is synchronous and active-high: clk_i, rst_i; one clock domain.

Function
REQ-004 Accept decode (combinational): opcode==7'b0001011, funct7==0, funct3 in {0,1,2,3}; else reject.
REQ-005 Ops: f3=0 rs0+rs1 mod 2^32; f3=1 rs0^rs1; f3=2 unsigned min(rs0,rs1); f3=3 rs0<<rs1[4:0].
REQ-006 issue_accept_o = issue_writeback_o = decode result, valid only while issue_valid_i; both 0 otherwise.
REQ-007 issue_ready_o = 1 when instruction rejected (consumed, not queued); when accepted, = (count<DEPTH) && issue_rs_valid_i==2'b11.
REQ-008 Full: count==DEPTH forces issue_ready_o=0 for accepted instructions even if a pop happens that cycle (no bypass).
REQ-009 Issue handshake (valid&&ready&&accept) SHALL enqueue at tail: id, rd=instr[11:7], computed result, committed=0, killed=0.
REQ-010 Commit: commit_valid_i marks the oldest valid entry with matching id committed (kill=0) or killed (kill=1); unmatched ids ignored, no error.
REQ-011 Commit in same cycle as issue handshake with same id and no existing match SHALL apply to the new entry.
REQ-012 Head killed -> popped next cycle with no result; one pop per cycle max.
REQ-013 Head committed and not killed -> result_valid_o=1 from next cycle: result_id_o, result_data_o, result_rd_o = head fields; result_we_o=1.
REQ-014 result_valid_o and all result fields SHALL stay stable until result_valid_o&&result_ready_i; pop on that edge.
REQ-015 Minimum latency: issue and commit at cycle N -> result_valid_o at N+1.
REQ-016 Results SHALL be returned strictly in issue order; a committed entry waits behind an uncommitted head.
REQ-017 Count/pointers wrap modulo DEPTH; simultaneous enqueue and pop leaves count unchanged.
REQ-018 Duplicate outstanding ids not checked; REQ-010 oldest-match rule applies.

Reset
REQ-019 rst_i high at an edge: queue emptied, count=0, all entry valid/committed/killed flags cleared.
REQ-020 Out of reset: result_valid_o=0, result_id_o=0, result_data_o=0, result_rd_o=0, result_we_o=0; issue_ready_o=1.
REQ-021 Reset mid-operation discards all outstanding entries; no result is produced for them after reset.

Verification
REQ-022 ADD id=3 rd=5 rs0=0xFFFF_FFFF rs1=2, commit id=3 same cycle -> next cycle result_valid_o=1, id=3, rd=5, data=0x0000_0001, we=1.
REQ-023 Instr opcode 0110011 issued -> issue_ready_o=1, issue_accept_o=0, no result ever.
REQ-024 Fill 4 entries ids 0-3 without commit -> issue_ready_o=0 for 5th accepted instr; commit id 0 and pop -> ready returns.
REQ-025 Issue ids 1,2 (XOR 0xA5,0x0F; MIN 7,9); commit 2 then 1 -> results in order id1 data 0xAA, id2 data 7.
REQ-026 Issue ids 4,5; kill 4, commit 5 -> only id 5 result; result held 3 cycles with result_ready_i=0, fields stable.
REQ-027 Two entries outstanding, rst_i pulsed one cycle -> result_valid_o=0, issue_ready_o=1; later commit of old ids gives no result.

Source files
------------

// File: rtl/xif_copro_issue_ctrl.sv
// rtl/xif_copro_issue_ctrl.sv - coprocessor end of the XIF issue/commit/result channels
// Executes custom-0 add/xor/min/shift at issue time and returns results in issue order once committed.
module xif_copro_issue_ctrl #(
  parameter int ID_WIDTH = 4,
  parameter int DEPTH    = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                issue_valid_i,
  output logic                issue_ready_o,
  input  logic [31:0]         issue_instr_i,
  input  logic [ID_WIDTH-1:0] issue_id_i,
  input  logic [31:0]         issue_rs0_i,
  input  logic [31:0]         issue_rs1_i,
  input  logic [1:0]          issue_rs_valid_i,
  output logic                issue_accept_o,
  output logic                issue_writeback_o,
  input  logic                commit_valid_i,
  input  logic [ID_WIDTH-1:0] commit_id_i,
  input  logic                commit_kill_i,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic [ID_WIDTH-1:0] result_id_o,
  output logic [31:0]         result_data_o,
  output logic [4:0]          result_rd_o,
  output logic                result_we_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ID_WIDTH-1:0] r_id   [DEPTH];
  logic [4:0]          r_rd   [DEPTH];
  logic [31:0]         r_data [DEPTH];
  logic [DEPTH-1:0]    r_vld;
  logic [DEPTH-1:0]    r_cmt;
  logic [DEPTH-1:0]    r_kill;
  logic [PTR_W-1:0]    r_head;
  logic [PTR_W-1:0]    r_tail;
  logic [CNT_W-1:0]    r_cnt;

  logic [2:0]          w_f3;
  logic                w_dec_ok;
  logic                w_space;
  logic                w_enq;
  logic [31:0]         w_alu;
  logic                w_cm_hit;
  logic [PTR_W-1:0]    w_cm_idx;
  logic [PTR_W-1:0]    w_scan;
  logic                w_cm_new;
  logic                w_head_vld;
  logic                w_res_vld;
  logic                w_pop;
  logic                w_unused_instr;

  assign w_f3           = issue_instr_i[14:12];
  assign w_dec_ok       = (issue_instr_i[6:0] == 7'b0001011) && (issue_instr_i[31:25] == 7'd0) && !w_f3[2];
  assign w_unused_instr = ^issue_instr_i[24:15];

  assign issue_accept_o    = issue_valid_i & w_dec_ok;
  assign issue_writeback_o = issue_valid_i & w_dec_ok;

  // Rejected instructions are always consumed; a full queue never takes a bypass from a same-cycle pop.
  assign w_space       = r_cnt < CNT_W'(DEPTH);
  assign issue_ready_o = !w_dec_ok || (w_space && (issue_rs_valid_i == 2'b11));
  assign w_enq         = issue_valid_i && issue_ready_o && w_dec_ok;

  always_comb begin
    w_alu = '0;
    case (w_f3[1:0])
      2'd0:    w_alu = issue_rs0_i + issue_rs1_i;
      2'd1:    w_alu = issue_rs0_i ^ issue_rs1_i;
      2'd2:    w_alu = (issue_rs0_i < issue_rs1_i) ? issue_rs0_i : issue_rs1_i;
      default: w_alu = issue_rs0_i << issue_rs1_i[4:0];
    endcase
  end

  // Scan youngest-to-oldest so the last hit written is the oldest matching entry.
  always_comb begin
    w_cm_hit = 1'b0;
    w_cm_idx = '0;
    w_scan   = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      w_scan = r_head + PTR_W'(k);
      if (r_vld[w_scan] && (r_id[w_scan] == commit_id_i)) begin
        w_cm_hit = 1'b1;
        w_cm_idx = w_scan;
      end
    end
  end

  assign w_cm_new = commit_valid_i && !w_cm_hit && w_enq && (issue_id_i == commit_id_i);

  assign w_head_vld = r_vld[r_head];
  assign w_res_vld  = w_head_vld && r_cmt[r_head] && !r_kill[r_head];
  assign w_pop      = w_head_vld && (r_kill[r_head] || (w_res_vld && result_ready_i));

  assign result_valid_o = w_res_vld;
  assign result_we_o    = w_res_vld;
  assign result_id_o    = w_res_vld ? r_id[r_head]   : '0;
  assign result_data_o  = w_res_vld ? r_data[r_head] : '0;
  assign result_rd_o    = w_res_vld ? r_rd[r_head]   : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vld  <= '0;
      r_cmt  <= '0;
      r_kill <= '0;
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else begin
      if (commit_valid_i && w_cm_hit) begin
        if (commit_kill_i) r_kill[w_cm_idx] <= 1'b1;
        else               r_cmt[w_cm_idx]  <= 1'b1;
      end
      if (w_enq) begin
        r_vld[r_tail]  <= 1'b1;
        r_cmt[r_tail]  <= w_cm_new && !commit_kill_i;
        r_kill[r_tail] <= w_cm_new && commit_kill_i;
        r_tail         <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + PTR_W'(1);
      end
      r_cnt <= r_cnt + CNT_W'(w_enq) - CNT_W'(w_pop);
    end
  end

  // Payload needs no reset: it is only observed through valid entries.
  always_ff @(posedge clk_i) begin
    if (w_enq) begin
      r_id[r_tail]   <= issue_id_i;
      r_rd[r_tail]   <= issue_instr_i[11:7];
      r_data[r_tail] <= w_alu;
    end
  end

endmodule

// File: tb/tb_xif_copro_issue_ctrl.sv
// tb/tb_xif_copro_issue_ctrl.sv - scoreboard bench for xif_copro_issue_ctrl
// Expected results are queued at issue and compared when the result channel handshakes.
module tb_xif_copro_issue_ctrl;

  typedef struct {
    logic [3:0]  id;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        issue_valid_i;
  logic        issue_ready_o;
  logic [31:0] issue_instr_i;
  logic [3:0]  issue_id_i;
  logic [31:0] issue_rs0_i;
  logic [31:0] issue_rs1_i;
  logic [1:0]  issue_rs_valid_i;
  logic        issue_accept_o;
  logic        issue_writeback_o;
  logic        commit_valid_i;
  logic [3:0]  commit_id_i;
  logic        commit_kill_i;
  logic        result_valid_o;
  logic        result_ready_i;
  logic [3:0]  result_id_o;
  logic [31:0] result_data_o;
  logic [4:0]  result_rd_o;
  logic        result_we_o;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  xif_copro_issue_ctrl #(.ID_WIDTH(4), .DEPTH(4)) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .issue_valid_i     (issue_valid_i),
    .issue_ready_o     (issue_ready_o),
    .issue_instr_i     (issue_instr_i),
    .issue_id_i        (issue_id_i),
    .issue_rs0_i       (issue_rs0_i),
    .issue_rs1_i       (issue_rs1_i),
    .issue_rs_valid_i  (issue_rs_valid_i),
    .issue_accept_o    (issue_accept_o),
    .issue_writeback_o (issue_writeback_o),
    .commit_valid_i    (commit_valid_i),
    .commit_id_i       (commit_id_i),
    .commit_kill_i     (commit_kill_i),
    .result_valid_o    (result_valid_o),
    .result_ready_i    (result_ready_i),
    .result_id_o       (result_id_o),
    .result_data_o     (result_data_o),
    .result_rd_o       (result_rd_o),
    .result_we_o       (result_we_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd);
    return {7'd0, 10'd0, f3, rd, 7'b0001011};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    issue_valid_i    = 1'b0;
    issue_instr_i    = '0;
    issue_id_i       = '0;
    issue_rs0_i      = '0;
    issue_rs1_i      = '0;
    issue_rs_valid_i = 2'b00;
    commit_valid_i   = 1'b0;
    commit_id_i      = '0;
    commit_kill_i    = 1'b0;
  endtask

  task automatic drive_issue(input logic [3:0] id, input logic [31:0] instr, input logic [31:0] a,
                             input logic [31:0] b, input logic cv, input logic [3:0] cid, input logic ck);
    issue_valid_i    = 1'b1;
    issue_instr_i    = instr;
    issue_id_i       = id;
    issue_rs0_i      = a;
    issue_rs1_i      = b;
    issue_rs_valid_i = 2'b11;
    commit_valid_i   = cv;
    commit_id_i      = cid;
    commit_kill_i    = ck;
  endtask

  task automatic drive_commit(input logic [3:0] cid, input logic ck);
    commit_valid_i = 1'b1;
    commit_id_i    = cid;
    commit_kill_i  = ck;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      step();
      n++;
    end
    check({"drain_", tag}, sb.size(), 0);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_i && result_valid_o && result_ready_i) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("res_id", {28'd0, result_id_o}, {28'd0, e.id});
        check("res_data", result_data_o, e.data);
        check("res_rd", {27'd0, result_rd_o}, {27'd0, e.rd});
        check("res_we", {31'd0, result_we_o}, 32'd1);
      end
    end
  end

  initial begin
    clear_in();
    result_ready_i = 1'b1;
    rst_i = 1'b1;
    repeat (3) step();
    rst_i = 1'b0;
    #1;
    check("rst_valid", {31'd0, result_valid_o}, 32'd0);
    check("rst_id", {28'd0, result_id_o}, 32'd0);
    check("rst_data", result_data_o, 32'd0);
    check("rst_rd", {27'd0, result_rd_o}, 32'd0);
    check("rst_we", {31'd0, result_we_o}, 32'd0);
    check("rst_ready", {31'd0, issue_ready_o}, 32'd1);

    // ADD wraps, committed in the issue cycle: result the next cycle
    sb.push_back('{4'd3, 5'd5, 32'h0000_0001});
    drive_issue(4'd3, mk(3'd0, 5'd5), 32'hFFFF_FFFF, 32'd2, 1'b1, 4'd3, 1'b0);
    #1;
    check("add_accept", {31'd0, issue_accept_o}, 32'd1);
    check("add_wb", {31'd0, issue_writeback_o}, 32'd1);
    check("add_ready", {31'd0, issue_ready_o}, 32'd1);
    check("add_pre_valid", {31'd0, result_valid_o}, 32'd0);
    step();
    clear_in();
    #1;
    check("add_latency", {31'd0, result_valid_o}, 32'd1);
    wait_drain("add");

    // shift uses only rs1[4:0]
    sb.push_back('{4'd9, 5'd12, 32'h0000_0020});
    drive_issue(4'd9, mk(3'd3, 5'd12), 32'd1, 32'h25, 1'b1, 4'd9, 1'b0);
    step();
    clear_in();
    wait_drain("sll");

    // rejected encodings are consumed and never produce results
    drive_issue(4'd0, 32'h0000_0033, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0);
    #1;
    check("rej_op_ready", {31'd0, issue_ready_o}, 32'd1);
    check("rej_op_accept", {31'd0, issue_accept_o}, 32'd0);
    check("rej_op_wb", {31'd0, issue_writeback_o}, 32'd0);
    issue_instr_i = mk(3'd0, 5'd1) | 32'h0200_0000;
    #1;
    check("rej_f7_accept", {31'd0, issue_accept_o}, 32'd0);
    issue_instr_i = mk(3'd4, 5'd1);
    #1;
    check("rej_f3_accept", {31'd0, issue_accept_o}, 32'd0);
    step();
    clear_in();
    for (int i = 0; i < 3; i++) begin
      step();
      check("rej_no_result", {31'd0, result_valid_o}, 32'd0);
    end

    // fill to DEPTH without commits
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{4'(i), 5'(i + 1), 32'(i + 100)});
      drive_issue(4'(i), mk(3'd0, 5'(i + 1)), 32'(i), 32'd100, 1'b0, 4'd0, 1'b0);
      step();
    end
    clear_in();
    drive_issue(4'd4, mk(3'd1, 5'd9), 32'd1, 32'd2, 1'b1, 4'd0, 1'b0);
    #1;
    check("full_ready", {31'd0, issue_ready_o}, 32'd0);
    check("full_accept", {31'd0, issue_accept_o}, 32'd1);
    step();
    commit_valid_i = 1'b0;
    #1;
    check("full_pop_valid", {31'd0, result_valid_o}, 32'd1);
    check("full_no_bypass", {31'd0, issue_ready_o}, 32'd0);
    step();
    check("full_ready_back", {31'd0, issue_ready_o}, 32'd1);
    issue_rs_valid_i = 2'b01;
    #1;
    check("rs_invalid_ready", {31'd0, issue_ready_o}, 32'd0);
    clear_in();
    for (int i = 1; i < 4; i++) begin
      drive_commit(4'(i), 1'b0);
      step();
    end
    clear_in();
    wait_drain("fill");

    // out-of-order commits still return in issue order
    sb.push_back('{4'd1, 5'd3, 32'h0000_00AA});
    drive_issue(4'd1, mk(3'd1, 5'd3), 32'hA5, 32'h0F, 1'b0, 4'd0, 1'b0);
    step();
    sb.push_back('{4'd2, 5'd4, 32'd7});
    drive_issue(4'd2, mk(3'd2, 5'd4), 32'd7, 32'd9, 1'b0, 4'd0, 1'b0);
    step();
    clear_in();
    drive_commit(4'd2, 1'b0);
    step();
    clear_in();
    #1;
    check("order_wait_head", {31'd0, result_valid_o}, 32'd0);
    step();
    check("order_wait_head2", {31'd0, result_valid_o}, 32'd0);
    drive_commit(4'd1, 1'b0);
    step();
    clear_in();
    wait_drain("order");

    // kill drops an entry; a held result stays stable
    result_ready_i = 1'b0;
    drive_issue(4'd4, mk(3'd0, 5'd6), 32'd1, 32'd1, 1'b0, 4'd0, 1'b0);
    step();
    sb.push_back('{4'd5, 5'd7, 32'd30});
    drive_issue(4'd5, mk(3'd0, 5'd7), 32'd10, 32'd20, 1'b0, 4'd0, 1'b0);
    step();
    clear_in();
    drive_commit(4'd4, 1'b1);
    step();
    drive_commit(4'd5, 1'b0);
    step();
    clear_in();
    for (int i = 0; i < 3; i++) begin
      check("hold_valid", {31'd0, result_valid_o}, 32'd1);
      check("hold_id", {28'd0, result_id_o}, 32'd5);
      check("hold_data", result_data_o, 32'd30);
      check("hold_rd", {27'd0, result_rd_o}, 32'd7);
      step();
    end
    result_ready_i = 1'b1;
    wait_drain("kill");

    // reset discards outstanding entries
    drive_issue(4'd6, mk(3'd0, 5'd1), 32'd1, 32'd2, 1'b0, 4'd0, 1'b0);
    step();
    drive_issue(4'd7, mk(3'd0, 5'd2), 32'd3, 32'd4, 1'b0, 4'd0, 1'b0);
    step();
    clear_in();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, result_valid_o}, 32'd0);
    drive_issue(4'd8, mk(3'd0, 5'd1), 32'd1, 32'd1, 1'b0, 4'd0, 1'b0);
    #1;
    check("mid_rst_ready", {31'd0, issue_ready_o}, 32'd1);
    clear_in();
    drive_commit(4'd6, 1'b0);
    step();
    drive_commit(4'd7, 1'b0);
    step();
    clear_in();
    for (int i = 0; i < 4; i++) begin
      check("mid_rst_no_result", {31'd0, result_valid_o}, 32'd0);
      step();
    end

    wait_drain("final");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
